// File: rtl/ifu_inst_sram_slave_if.sv
// AR/R channel bundle between the ifu (master) and its instruction SRAM slave.
// Signal names keep their original ifu_* port names.
interface ifu_inst_sram_slave_if;
  logic        ifu_arvalid;
  logic        ifu_arready;
  logic [63:0] ifu_araddr;
  logic        ifu_rvalid;
  logic        ifu_rready;
  logic [1:0]  ifu_rresp;
  logic [31:0] ifu_rdata;

  modport master (
    output ifu_arvalid, ifu_araddr, ifu_rready,
    input  ifu_arready, ifu_rvalid, ifu_rresp, ifu_rdata
  );

  modport slave (
    input  ifu_arvalid, ifu_araddr, ifu_rready,
    output ifu_arready, ifu_rvalid, ifu_rresp, ifu_rdata
  );
endinterface

// File: rtl/ifu_inst_sram_slave.sv
// Read-only AXI-lite instruction memory: fixed-latency read pipeline feeding an
// in-order response queue, with a backdoor preload write port.
module ifu_inst_sram_slave #(
  parameter logic [63:0] ADDR_BASE = 64'h8000_0000,
  parameter int unsigned AW        = 12,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned QDEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  ifu_inst_sram_slave_if.slave   bus,
  input  logic                   ld_en,
  input  logic [AW-1:0]          ld_addr,
  input  logic [31:0]            ld_data
);

  localparam int unsigned CW    = $clog2(QDEPTH + 1);
  localparam int unsigned QW    = $clog2(QDEPTH);
  localparam int unsigned DEPTH = 1 << AW;

  logic [31:0]   mem [DEPTH];
  logic [63:0]   off;
  logic          in_range;
  logic [AW-1:0] widx;
  logic          ar_hs;
  logic          r_hs;
  logic [CW-1:0] out_cnt;

  logic [LATENCY-1:0] pv;
  logic [33:0]        pe [LATENCY];

  logic [33:0]   qm [QDEPTH];
  logic [QW-1:0] wp;
  logic [QW-1:0] rp;
  logic [CW-1:0] qc;
  logic          push;

  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  assign off      = bus.ifu_araddr - ADDR_BASE;
  assign in_range = (bus.ifu_araddr >= ADDR_BASE) && (off < (64'd4 << AW));
  assign widx     = off[AW+1:2];

  assign bus.ifu_arready = (out_cnt != CW'(QDEPTH));
  assign bus.ifu_rvalid  = (qc != '0);
  assign ar_hs           = bus.ifu_arvalid & bus.ifu_arready;
  assign r_hs            = bus.ifu_rvalid & bus.ifu_rready;
  assign push            = pv[LATENCY-1];

  assign {bus.ifu_rresp, bus.ifu_rdata} = bus.ifu_rvalid ? qm[rp] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt <= '0;
    end else begin
      case ({ar_hs, r_hs})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pv <= '0;
    end else begin
      pv[0] <= ar_hs;
      for (int unsigned i = 1; i < LATENCY; i++) pv[i] <= pv[i-1];
    end
  end

  // Nonblocking read of mem returns the pre-write word when ld_en hits the same index.
  always_ff @(posedge clk) begin
    if (ar_hs) pe[0] <= in_range ? {2'b00, mem[widx]} : {2'b11, 32'h0};
    for (int unsigned i = 1; i < LATENCY; i++) pe[i] <= pe[i-1];
  end

  always_ff @(posedge clk) begin
    if (push) qm[wp] <= pe[LATENCY-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      qc <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (r_hs) rp <= rp + 1'b1;
      case ({push, r_hs})
        2'b10:   qc <= qc + 1'b1;
        2'b01:   qc <= qc - 1'b1;
        default: qc <= qc;
      endcase
    end
  end

endmodule
